mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator-side load/store engine that drives the byte-enabled single-port data RAM: address, data_in, write_enable[3:0], read_enable out; data_out in.
- Sits between the CPU execute/memory stage and the RAM.
- Accepts one RV32 load/store request per valid/ready handshake and generates the RAM byte mask and lane-shifted write data.
- Waits the RAM read latency, then extracts and sign/zero-extends load data.
- Returns one response per request and flags misaligned or illegal accesses without touching the RAM.

Parameters:
READ_LATENCY, 1, cycles from the edge sampling mem_read_enable high to the edge on which mem_data_out is valid (legal 1..7)
ADDR_WIDTH, 32, width of req_addr and mem_address

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 width/sign code
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present; held until resp_ready
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_misaligned  out  1  access not naturally aligned
resp_illegal  out  1  unsupported funct3
mem_address  out  ADDR_WIDTH  word-aligned byte address {req_addr[ADDR_WIDTH-1:2],2'b00}
mem_data_in  out  32  lane-replicated write data
mem_write_enable  out  4  byte-lane write mask
mem_read_enable  out  1  read strobe
mem_data_out  in  32  RAM read data

Behaviour:
- Reset: all outputs 0, FSM = IDLE, latency counter 0.
- rst_n low on any edge aborts an in-flight access. mem_write_enable and mem_read_enable are 0 from that edge, and no response is produced.
- FSM states are IDLE, WRITE, READ, WAIT, RESP.
- IDLE: req_ready=1. On an edge with req_valid&&req_ready, latch write, funct3, addr and wdata.
- Legal funct3: stores 000/001/010; loads 000/001/010/100/101. Anything else is illegal, with resp_illegal=1.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. Illegal takes precedence; resp_misaligned=0 when illegal.
- Fault (illegal or misaligned): IDLE goes directly to RESP. No RAM strobe is ever asserted. resp_rdata=0.
- Store to WRITE: mem_write_enable is set for exactly one cycle.
  - SB: mask 0001<<addr[1:0], data {4{wdata[7:0]}}.
  - SH: mask 0011<<(2*addr[1]), data {2{wdata[15:0]}}.
  - SW: mask 1111, data wdata.
  - Then go to RESP.
- Load to READ: mem_read_enable=1 for exactly one cycle. Then WAIT for READ_LATENCY cycles, counting down from READ_LATENCY-1.
  - mem_data_out is captured on the last WAIT edge. Then go to RESP.
  - Lane select: byte = data>>(8*addr[1:0]); half = data>>(16*addr[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- mem_address and mem_data_in are registered on acceptance. They hold their value until the next acceptance and are never X after reset.
- RESP: resp_valid=1, with resp_* stable until an edge with resp_ready=1, then go to IDLE. req_ready stays 0 throughout RESP.
- Latency from the accept edge N:
  - Store: mem_write_enable high during cycle N+1; resp_valid from N+2.
  - Load: mem_read_enable high during N+1; resp_valid from N+2+READ_LATENCY.
  - Fault: resp_valid from N+1.
- Back-to-back: with resp_ready tied high, the next request is accepted on the cycle after the response edge.
- req_valid while not in IDLE is ignored; it is not latched.

Optional Feature:
- Macro MEM_ACCESS_STATS_EN.
- Defined: adds outputs stat_loads[31:0], stat_stores[31:0] and stat_faults[31:0].
  - Each increments by 1 on the response handshake edge of a completed load, completed store, or fault respectively.
  - Counters wrap 0xFFFFFFFF to 0 and reset to 0.
- Undefined: no such ports or logic exist.

Test Plan:
- SB addr=10, wdata=0x0000002A, then LBU addr=10 -> write cycle shows mask 0100 and data_in 0x2A2A2A2A; load resp_rdata=0x0000002A, resp_valid at N+3 (READ_LATENCY=1).
- SW addr=0x20 wdata=0x80FF7F01; LB addr=0x22 -> 0xFFFFFFFF; LBU addr=0x23 -> 0x00000080; LH addr=0x22 -> 0xFFFF80FF; LHU addr=0x20 -> 0x00007F01.
- LW addr=1 and SH addr=3 -> resp_misaligned=1, resp_rdata=0; mem_read_enable and mem_write_enable stay 0 throughout.
- Load with funct3=011, and store with funct3=100 -> resp_illegal=1, resp_misaligned=0, no RAM strobe.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0, a second req_valid is ignored. Deassert rst_n during the WRITE cycle -> mem_write_enable=0 next edge, no response, req_ready=1 after reset.
- READ_LATENCY=3, SW then LW at the same address -> resp_valid exactly at N+5 with the written word. With MEM_ACCESS_STATS_EN defined, stat_stores=1, stat_loads=1, stat_faults=0.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// ----------------------------------------------------------------------------
// mem_access_unit_if
// Groups the CPU-side request/response handshake and the RAM-side bus of
// mem_access_unit into one bundle.
//   slave  : view used by mem_access_unit (accepts requests, drives the RAM)
//   master : view used by the CPU stage / RAM side (issues requests, returns
//            read data)
// Signals:
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata  request
//   resp_valid/resp_ready/resp_rdata/resp_misaligned/resp_illegal response
//   mem_address/mem_data_in/mem_write_enable/mem_read_enable      RAM strobes
//   mem_data_out                                                  RAM read data
// ----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_misaligned;
    logic                  resp_illegal;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data_in;
    logic [3:0]            mem_write_enable;
    logic                  mem_read_enable;
    logic [31:0]           mem_data_out;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        output mem_address, mem_data_in, mem_write_enable, mem_read_enable
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        input  mem_address, mem_data_in, mem_write_enable, mem_read_enable
    );
endinterface

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// RV32 load/store engine between the execute/memory stage and a byte-enabled
// single-port data RAM. One request per handshake; stores produce a byte mask
// and lane-replicated data, loads wait READ_LATENCY cycles and then extract
// and sign/zero-extend the addressed lane. Misaligned or illegal accesses are
// answered directly without any RAM strobe.
// Ports:
//   clk    : clock, all logic on posedge
//   rst_n  : synchronous active-low reset
//   bus    : mem_access_unit_if.slave (request, response and RAM signals)
//   stat_loads/stat_stores/stat_faults : completion counters, present only
//            when MEM_ACCESS_STATS_EN is defined
// Parameters:
//   READ_LATENCY : RAM read latency in cycles (1..7)
//   ADDR_WIDTH   : byte address width
// ----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_unit_if.slave    bus
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [31:0]         stat_loads,
    output logic [31:0]         stat_stores,
    output logic [31:0]         stat_faults
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    function automatic logic is_illegal(input logic wr, input logic [2:0] f3);
        logic ill;
        if (wr) begin
            ill = !(f3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            ill = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        return ill;
    endfunction

    // f3[1:0] encodes the access size for both signed and unsigned loads.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] m;
        case (f3)
            3'b000:  m = 4'b0001 << lo;
            3'b001:  m = 4'b0011 << {lo[1], 1'b0};
            3'b010:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            3'b000:  d = {4{wd[7:0]}};
            3'b001:  d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(data >> {lo, 3'b000});
        h = 16'(data >> {lo[1], 4'b0000});
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = data;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_mis_q, resp_mis_d;
    logic                  resp_ill_q, resp_ill_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [31:0]           mem_data_in_q, mem_data_in_d;
    logic [3:0]            mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic                  illegal_s;
    logic                  misaligned_s;
`ifdef MEM_ACCESS_STATS_EN
    logic                  write_q, write_d;
    logic [31:0]           stat_loads_q, stat_loads_d;
    logic [31:0]           stat_stores_q, stat_stores_d;
    logic [31:0]           stat_faults_q, stat_faults_d;
`endif

    assign illegal_s    = is_illegal(bus.req_write, bus.req_funct3);
    assign misaligned_s = !illegal_s && is_misaligned(bus.req_funct3, bus.req_addr[1:0]);

    // Next-state and next-output computation for the access FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        funct3_d      = funct3_q;
        addr_lo_d     = addr_lo_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_mis_d    = resp_mis_q;
        resp_ill_d    = resp_ill_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        // Strobes are single-cycle pulses: they drop unless re-asserted here.
        mem_we_d      = 4'b0000;
        mem_re_d      = 1'b0;
`ifdef MEM_ACCESS_STATS_EN
        write_d       = write_q;
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        stat_faults_d = stat_faults_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    funct3_d      = bus.req_funct3;
                    addr_lo_d     = bus.req_addr[1:0];
                    mem_address_d = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_data_in_d = store_data(bus.req_funct3, bus.req_wdata);
`ifdef MEM_ACCESS_STATS_EN
                    write_d       = bus.req_write;
`endif
                    if (illegal_s || misaligned_s) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'h0000_0000;
                        resp_ill_d   = illegal_s;
                        resp_mis_d   = misaligned_s;
                    end else if (bus.req_write) begin
                        state_d  = ST_WRITE;
                        mem_we_d = store_mask(bus.req_funct3, bus.req_addr[1:0]);
                    end else begin
                        state_d  = ST_READ;
                        mem_re_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0000_0000;
                resp_ill_d   = 1'b0;
                resp_mis_d   = 1'b0;
            end
            ST_READ: begin
                state_d = ST_WAIT;
                cnt_d   = 3'(READ_LATENCY - 1);
            end
            ST_WAIT: begin
                // Count reaching zero marks the edge on which RAM data is valid.
                if (cnt_q == 3'd0) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extract(funct3_q, addr_lo_q, bus.mem_data_out);
                    resp_ill_d   = 1'b0;
                    resp_mis_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0000_0000;
                    resp_ill_d   = 1'b0;
                    resp_mis_d   = 1'b0;
`ifdef MEM_ACCESS_STATS_EN
                    if (resp_ill_q || resp_mis_q) begin
                        stat_faults_d = stat_faults_q + 32'd1;
                    end else if (write_q) begin
                        stat_stores_d = stat_stores_q + 32'd1;
                    end else begin
                        stat_loads_d = stat_loads_q + 32'd1;
                    end
`endif
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            funct3_q      <= 3'b000;
            addr_lo_q     <= 2'b00;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'h0000_0000;
            resp_mis_q    <= 1'b0;
            resp_ill_q    <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= 32'h0000_0000;
            mem_we_q      <= 4'b0000;
            mem_re_q      <= 1'b0;
`ifdef MEM_ACCESS_STATS_EN
            write_q       <= 1'b0;
            stat_loads_q  <= 32'h0000_0000;
            stat_stores_q <= 32'h0000_0000;
            stat_faults_q <= 32'h0000_0000;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            funct3_q      <= funct3_d;
            addr_lo_q     <= addr_lo_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_mis_q    <= resp_mis_d;
            resp_ill_q    <= resp_ill_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
`ifdef MEM_ACCESS_STATS_EN
            write_q       <= write_d;
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_faults_q <= stat_faults_d;
`endif
        end
    end

    assign bus.req_ready        = req_ready_q;
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_rdata       = resp_rdata_q;
    assign bus.resp_misaligned  = resp_mis_q;
    assign bus.resp_illegal     = resp_ill_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_data_in      = mem_data_in_q;
    assign bus.mem_write_enable = mem_we_q;
    assign bus.mem_read_enable  = mem_re_q;
`ifdef MEM_ACCESS_STATS_EN
    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_faults = stat_faults_q;
`endif

endmodule
